// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick function for the fifo push arbiter.
// rr_pick works on a fixed 8-wide request vector; callers zero-extend.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int RR_MAX_REQ = 8;
  localparam int RR_IDX_W   = 3;

  // First set bit of valid, searching upward from last_owner+1 with wrap at nreq.
  function automatic logic [RR_IDX_W-1:0] rr_pick(
    input logic [RR_MAX_REQ-1:0] valid,
    input logic [RR_IDX_W-1:0]   last_owner,
    input int                    nreq
  );
    logic [RR_IDX_W-1:0] pick;
    logic [RR_IDX_W-1:0] idx3;
    logic                hit;
    int                  idx;
    pick = '0;
    hit  = 1'b0;
    for (int k = 1; k <= RR_MAX_REQ; k++) begin
      idx  = (int'(last_owner) + k) % nreq;
      idx3 = idx[RR_IDX_W-1:0];
      if (k <= nreq && !hit && valid[idx3]) begin
        pick = idx3;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_push_arb_rr_select.sv
// Combinational round-robin priority encoder: returns the first valid index
// after ptr (wrapping), plus a found flag. Zero latency, no flow control.
module rr_select
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  always_comb begin
    found = |valid;
    idx   = IDW'(rr_pick(RR_MAX_REQ'(valid), RR_IDX_W'(ptr), NREQ));
  end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin arbiter sharing one fifo push port among NREQ producers, bursts of up to MAX_BURST beats.
// One idle arbitration cycle per grant; fifo_full stalls the owner without revoking its grant.
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int width     = 8,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*width-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_push,
  output logic [width-1:0]      fifo_datain,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_owner_q, last_owner_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

  logic [IDW-1:0]   pick;
  logic             found;
  logic             own_vld;
  logic             own_last;
  logic [width-1:0] own_dat;
  logic [BCW-1:0]   beat_nxt;
  logic             end_burst;

  rr_select #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_select (
    .valid (req_valid),
    .ptr   (last_owner_q),
    .idx   (pick),
    .found (found)
  );

  // Owner's lane, selected with constant indices so non-power-of-two NREQ stays in range.
  always_comb begin
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_dat  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDW'(i)) begin
        own_vld  = req_valid[i];
        own_last = req_last[i];
        own_dat  = req_data[i*width +: width];
      end
    end
  end

  always_comb begin
    busy        = (state_q == BURST);
    grant_id    = owner_q;
    req_ready   = '0;
    fifo_push   = 1'b0;
    fifo_datain = '0;
    if (state_q == BURST) begin
      for (int i = 0; i < NREQ; i++) begin
        if (owner_q == IDW'(i)) req_ready[i] = ~fifo_full;
      end
      fifo_push   = own_vld & ~fifo_full;
      fifo_datain = own_dat;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    beat_nxt     = beat_cnt_q + BCW'(1);
    end_burst    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d    = pick;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // A stalled owner (fifo_full) neither counts nor loses the grant.
        if (fifo_push) begin
          beat_cnt_d = beat_nxt;
          if (own_last || beat_nxt == BCW'(MAX_BURST)) end_burst = 1'b1;
        end else if (!own_vld && !fifo_full) begin
          end_burst = 1'b1;
        end
        if (end_burst) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IDW'(NREQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Scoreboard bench for fifo_push_arb: random/directed producers, reference arbiter model, negedge monitor.
module tb_fifo_push_arb;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int MAXB = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NREQ-1:0]     req_valid, req_last, req_ready;
  logic [NREQ*W-1:0]   req_data;
  logic                fifo_full, fifo_push;
  logic [W-1:0]        fifo_datain;
  logic [IDW-1:0]      grant_id;
  logic                busy;

  fifo_push_arb #(.NREQ(NREQ), .width(W), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_push(fifo_push),
    .fifo_datain(fifo_datain), .grant_id(grant_id), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // producer state
  logic [NREQ-1:0] vld_r = '0, last_r = '0, xfer = '0, mask = '0;
  logic [W-1:0]    dat_r [NREQ];
  logic            full_r = 1'b0;
  int              seq [NREQ];
  int              pbeat [NREQ];
  int              pv = 100, plen_fixed = 1000, full_force = 0, pf = 0;
  bit              in_reset = 1'b1;

  // reference model: grant owner, beats so far, previous owner
  bit  m_granted;
  int  m_owner, m_last, m_beats;
  logic [NREQ-1:0] exp_ready = '0;
  logic            exp_push = 1'b0, exp_busy = 1'b0;
  int              exp_gid = 0;
  logic [W-1:0]    expq[$];

  int   npush = 0;
  int   glog[$];
  logic prev_busy = 1'b0;

  task automatic model_reset();
    m_granted = 1'b0; m_owner = 0; m_last = NREQ - 1; m_beats = 0;
    expq.delete();
    exp_ready = '0; exp_push = 1'b0; exp_busy = 1'b0; exp_gid = 0;
  endtask

  task automatic model_step();
    int idx;
    exp_ready = '0; exp_push = 1'b0;
    exp_busy  = m_granted; exp_gid = m_owner;
    if (!m_granted) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (!m_granted && vld_r[idx]) begin
          m_granted = 1'b1; m_owner = idx; m_beats = 0;
        end
      end
    end else if (!full_r) begin
      exp_ready[m_owner] = 1'b1;
      if (vld_r[m_owner]) begin
        exp_push = 1'b1;
        xfer[m_owner] = 1'b1;
        expq.push_back(dat_r[m_owner]);
        m_beats++;
        if (last_r[m_owner] || m_beats == MAXB) begin m_granted = 1'b0; m_last = m_owner; end
      end else begin
        m_granted = 1'b0; m_last = m_owner;
      end
    end
  endtask

  task automatic step(input bit pulse);
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer[i]) begin
        seq[i]   = (seq[i] + 1) % 64;
        pbeat[i] = last_r[i] ? 0 : pbeat[i] + 1;
      end
      if (xfer[i] || !vld_r[i]) begin
        vld_r[i]  = mask[i] && ($urandom_range(99) < pv);
        dat_r[i]  = W'(i * 64 + seq[i]);
        last_r[i] = (plen_fixed > 0) ? (pbeat[i] == plen_fixed - 1) : ($urandom_range(3) == 0);
      end
    end
    full_r = (full_force >= 0) ? full_force[0] : ($urandom_range(99) < pf);
    req_valid = vld_r; req_last = last_r; fifo_full = full_r;
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = dat_r[i];
    rst  = in_reset ? 1'b0 : 1'b1;
    xfer = '0;
    if (pulse) begin
      rst = 1'b0; #1;
      chk("pulse_req_ready", req_ready, 0);
      chk("pulse_fifo_push", fifo_push, 0);
      chk("pulse_busy", busy, 0);
      chk("pulse_grant_id", grant_id, 0);
      rst = 1'b1; #1;
      model_reset();
    end
    if (in_reset) model_reset();
    else model_step();
  endtask

  task automatic setup(input logic [NREQ-1:0] m, input int p, input int plen, input int ff);
    mask = m; pv = p; plen_fixed = plen; full_force = ff;
    vld_r = '0; xfer = '0;
    for (int i = 0; i < NREQ; i++) pbeat[i] = 0;
    in_reset = 1'b1;
    step(0); step(0);
    in_reset = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // monitor: per-cycle handshake checks and scoreboard pop on every push
  always @(negedge clk) begin
    chk("req_ready", req_ready, exp_ready);
    chk("busy", busy, exp_busy);
    chk("fifo_push", fifo_push, exp_push);
    if (exp_busy) chk("grant_id", grant_id, exp_gid);
    if (busy && !prev_busy) glog.push_back(int'(grant_id));
    prev_busy = busy;
    if (fifo_push) begin
      npush++;
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_push: got data %0d expected no push at %0t", fifo_datain, $time);
      end else begin
        chk("fifo_datain", fifo_datain, expq.pop_front());
      end
    end
  end

  int n0;
  int exp_g2[5] = '{0, 1, 2, 3, 0};
  int exp_g5[3] = '{0, 3, 0};
  int exp_g6[3] = '{0, 1, 0};

  initial begin
    rst = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin seq[i] = 0; pbeat[i] = 0; dat_r[i] = '0; end
    model_reset();

    // reset with all requesters valid
    mask = '1; pv = 100; plen_fixed = 1000; full_force = 0;
    step(0); step(0);
    settle();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_fifo_push", fifo_push, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    in_reset = 1'b0;
    step(0); step(0);
    settle();
    chk("first_grant_busy", busy, 1);
    chk("first_grant_id", grant_id, 0);

    // round-robin, long packets
    setup('1, 100, 1000, 0);
    glog.delete(); n0 = npush;
    repeat (21) step(0);
    settle();
    chk("rr_push_count", npush - n0, 16);
    repeat (4) step(0);
    settle();
    chk("rr_grant_count", glog.size(), 5);
    for (int i = 0; i < 5; i++) chk("rr_grant_order", (i < glog.size()) ? glog[i] : -1, exp_g2[i]);

    // short packet on req 2
    setup(4'b0100, 100, 2, 0);
    n0 = npush;
    repeat (3) step(0);
    settle();
    chk("short_push_count", npush - n0, 2);
    step(0); settle();
    chk("short_idle_busy", busy, 0);
    step(0); settle();
    chk("short_regrant_busy", busy, 1);
    chk("short_regrant_id", grant_id, 2);

    // backpressure on owner 1 after two beats
    setup(4'b0010, 100, 1000, 0);
    n0 = npush;
    repeat (3) step(0);
    settle();
    chk("bp_pre_push_count", npush - n0, 2);
    full_force = 1;
    repeat (5) step(0);
    settle();
    chk("bp_stall_push_count", npush - n0, 2);
    chk("bp_stall_busy", busy, 1);
    chk("bp_stall_grant_id", grant_id, 1);
    chk("bp_stall_ready", req_ready, 0);
    full_force = 0;
    repeat (2) step(0);
    settle();
    chk("bp_resume_push_count", npush - n0, 4);
    step(0); settle();
    chk("bp_exit_busy", busy, 0);

    // owner 0 drops valid after one beat, then wrap 3 -> 0
    setup(4'b1001, 100, 1000, 0);
    glog.delete();
    repeat (2) step(0);
    mask = 4'b1000;
    step(0);
    mask = 4'b1001;
    repeat (7) step(0);
    settle();
    chk("drop_grant_count", glog.size(), 3);
    for (int i = 0; i < 3; i++) chk("drop_grant_order", (i < glog.size()) ? glog[i] : -1, exp_g5[i]);

    // async reset pulse in the middle of grant 1
    setup('1, 100, 1000, 0);
    glog.delete();
    repeat (7) step(0);
    step(1);
    repeat (3) step(0);
    settle();
    chk("arst_grant_count", glog.size(), 3);
    for (int i = 0; i < 3; i++) chk("arst_grant_order", (i < glog.size()) ? glog[i] : -1, exp_g6[i]);

    // random traffic with random backpressure and packet ends
    setup('1, 70, 0, -1);
    pf = 25;
    repeat (3000) step(0);
    mask = '0; full_force = 0;
    repeat (8) step(0);
    settle();
    chk("scoreboard_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_push_arb.md
Name: fifo_push_arb

Overview:
Round-robin write-side arbiter that shares the push port of one fifo among NREQ producers. Each producer has a valid/ready/last handshake. The arbiter grants one producer at a time for a bounded burst, then drives the fifo push/datain from that producer and honours fifo full as backpressure. It sits between the producer blocks and the fifo instance; the fifo's pop side is untouched.

Parameters:
NREQ, 4, number of requesters (2..8)
width, 8, data width; must match the fifo width
MAX_BURST, 4, maximum beats per grant (1..16)
IDW, $clog2(NREQ), width of grant_id (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  NREQ  per-requester data valid
req_last  input  NREQ  per-requester end-of-packet; sampled only on a transfer beat
req_data  input  NREQ*width  packed data; requester i occupies [i*width +: width]
req_ready  output  NREQ  per-requester accept; a beat transfers when valid & ready
fifo_full  input  1  full flag from the fifo
fifo_push  output  1  push strobe to the fifo
fifo_datain  output  width  data to the fifo
grant_id  output  IDW  index of the current owner; valid while busy=1
busy  output  1  1 while in BURST state

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, owner=0, last_owner=NREQ-1, beat_cnt=0. Outputs: req_ready=0, fifo_push=0, busy=0, grant_id=0. fifo_datain is don't-care and is driven 0.
- FSM has two states, IDLE and BURST. All state is held in flops. Outputs are combinational from state/owner plus the live inputs.
- IDLE:
  - If any req_valid=1, pick the first index with valid=1 searching upward from (last_owner+1) mod NREQ, with wrap-around.
  - Latch it into owner. Set beat_cnt=0. Go to BURST.
  - No transfer happens in IDLE, so arbitration latency is 1 cycle.
- BURST:
  - req_ready[owner] = ~fifo_full. All other ready bits are 0.
  - fifo_push = req_valid[owner] & ~fifo_full.
  - fifo_datain = req_data slice of owner.
  - A beat is fifo_push=1. Each beat increments beat_cnt.
- BURST exit to IDLE, with last_owner set to owner, on any of:
  - a beat with req_last[owner]=1;
  - a beat that makes beat_cnt reach MAX_BURST;
  - req_valid[owner]=0 while fifo_full=0 (owner went idle; no beat that cycle).
  - The exit transition happens at the end of the cycle in which the condition holds.
- fifo_full=1 in BURST: no beat, no count, and the owner keeps the grant. A grant is never revoked while fifo_full=1.
- Each grant gives at most MAX_BURST beats.
- The 1-cycle IDLE bubble between grants is required.
- Fairness: with all requesters valid and producing long packets, grants rotate 0,1,2,3,0,… Each requester waits at most (NREQ-1)*(MAX_BURST+1)+1 cycles once fifo_full is clear, including the arbitration cycle.
- beat_cnt width is $clog2(MAX_BURST+1) and it never wraps.
- Requester data must be held stable while valid=1 and ready=0. The arbiter does not check this.
- Reset asserted mid-burst: everything returns to reset values immediately, and the partial packet is abandoned. The arbiter has no recovery duty.

Decomposition:
- Package fifo_arb_pkg holds the state enum (IDLE, BURST) and a function rr_pick(valid, last_owner) returning the next index.
- One sub-module, rr_select: a combinational round-robin priority encoder (valid vector + pointer → index + found).

Test Plan:
1. Reset: hold rst=0 with all req_valid=1 → req_ready=0, fifo_push=0, busy=0. Release → next edge busy=1, grant_id=0.
2. Round-robin: all four valid, last never asserted, fifo_full=0 → grants 0,1,2,3,0. Exactly 4 pushes per grant with a 1-cycle gap between grants. Data order matches each owner's stream.
3. Short packet: only req 2 valid, last=1 on its 2nd beat → 2 pushes, then IDLE. The next grant goes to req 2 again if still valid.
4. Backpressure: owner 1 mid-burst (beat_cnt=2), fifo_full=1 for 5 cycles → fifo_push=0 and req_ready[1]=0, grant held. Resume → 2 more beats, then exit.
5. Owner drops valid: req 0 deasserts after 1 beat while req 3 is valid → IDLE, then grant_id=3. A further pass checks that wrap-around 3→0 selects req 0.
6. Async reset mid-burst: pulse rst low between edges during grant 1 → outputs go to reset values without waiting for clk. After release, arbitration restarts at req 0.
